// File: rtl/gsm_at_resp_parser_pkg.sv
// Shared GSM link definitions: ASCII codes, line FSM encoding and default timeout.
// Imported by the response parser and its timeout timer.
package gsm_at_resp_parser_pkg;

  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_GT  = 8'h3E;
  localparam logic [7:0] ASC_MAX = 8'h7E;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;

  localparam logic [15:0] STR_OK    = "OK";
  localparam logic [39:0] STR_ERROR = "ERROR";
  localparam logic [79:0] STR_CME   = "+CME ERROR";

  typedef enum logic {
    LINE_IDLE = 1'b0,
    LINE_FILL = 1'b1
  } line_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASC_SP) && (b <= ASC_MAX);
  endfunction

endpackage

// File: rtl/at_timeout_timer.sv
// Response timeout: load on command sent, count down while busy, strobe expire once.
// A clear (terminating response) ends the wait without an expire strobe.
module at_timeout_timer
  import gsm_at_resp_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic busy,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // The load cycle itself counts, so expire lands TIMEOUT_CYCLES cycles after the load strobe.
  localparam logic [CntW-1:0] Reload = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      busy   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        busy <= 1'b1;
        cnt  <= Reload;
      end else if (clear) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        if (cnt <= CntW'(1)) begin
          busy   <= 1'b0;
          expire <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt - CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gsm_at_resp_parser.sv
// Assembles CR/LF-terminated modem lines, classifies OK / ERROR / "> " prompt,
// and tracks the response timeout for the AT command sender.
module gsm_at_resp_parser
  import gsm_at_resp_parser_pkg::*;
#(
  parameter int unsigned LINE_CHARS     = 14,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    cmd_sent,
  output logic [LINE_CHARS*8-1:0] line_text,
  output logic                    line_valid,
  output logic                    resp_ok,
  output logic                    resp_error,
  output logic                    resp_prompt,
  output logic                    resp_timeout,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned TextW = LINE_CHARS * 8;
  localparam int unsigned LenW  = $clog2(LINE_CHARS + 1);
  localparam logic [TextW-1:0] Blank   = {LINE_CHARS{ASC_SP}};
  localparam logic [LenW-1:0]  LenFull = LenW'(LINE_CHARS);

  line_state_e      state;
  logic [TextW-1:0] line_buf;
  logic [TextW-1:0] buf_app;
  logic [LenW-1:0]  len;
  logic             trunc;

  logic printable, is_term, is_prompt, is_append, is_drop;
  logic hit_ok, hit_err, resp_hit;

  // Buffer stays space-padded past len, so appending is a single byte write.
  always_comb begin
    buf_app = line_buf;
    for (int i = 0; i < LINE_CHARS; i++) begin
      if (len == LenW'(i)) buf_app[TextW-8-8*i +: 8] = rx_data;
    end
  end

  always_comb begin
    printable = is_printable(rx_data);
    is_term   = rx_valid && (rx_data == ASC_LF) && (state == LINE_FILL);
    is_prompt = rx_valid && (rx_data == ASC_SP) && (len == LenW'(1)) &&
                (line_buf[TextW-1 -: 8] == ASC_GT);
    is_append = rx_valid && printable && !is_prompt && (len != LenFull);
    is_drop   = rx_valid && printable && !is_prompt && (len == LenFull);
    hit_ok    = is_term && !trunc && (len == LenW'(2)) && (line_buf[TextW-1 -: 16] == STR_OK);
    hit_err   = is_term &&
                (((len == LenW'(5)) && (line_buf[TextW-1 -: 40] == STR_ERROR)) ||
                 ((len >= LenW'(10)) && (line_buf[TextW-1 -: 80] == STR_CME)));
    resp_hit  = hit_ok || hit_err || is_prompt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LINE_IDLE;
      line_buf    <= Blank;
      len         <= '0;
      trunc       <= 1'b0;
      line_text   <= Blank;
      line_valid  <= 1'b0;
      resp_ok     <= 1'b0;
      resp_error  <= 1'b0;
      resp_prompt <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      line_valid  <= 1'b0;
      resp_ok     <= 1'b0;
      resp_error  <= 1'b0;
      resp_prompt <= 1'b0;
      if (cmd_sent) overflow <= 1'b0;
      if (is_term || is_prompt) begin
        line_text   <= is_prompt ? buf_app : line_buf;
        line_valid  <= 1'b1;
        resp_ok     <= hit_ok;
        resp_error  <= hit_err;
        resp_prompt <= is_prompt;
        line_buf    <= Blank;
        len         <= '0;
        trunc       <= 1'b0;
        state       <= LINE_IDLE;
      end else if (is_append) begin
        line_buf <= buf_app;
        len      <= len + LenW'(1);
        state    <= LINE_FILL;
      end else if (is_drop) begin
        overflow <= 1'b1;
        trunc    <= 1'b1;
      end
    end
  end

  at_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cmd_sent),
    .clear (resp_hit),
    .busy  (busy),
    .expire(resp_timeout)
  );

endmodule

// File: tb/tb_gsm_at_resp_parser.sv
// Bench for gsm_at_resp_parser: directed scenarios with literal expectations plus
// randomized byte streams checked every cycle against a queue-based line model.
module tb_gsm_at_resp_parser;

  localparam int LC = 14;
  localparam int TW = LC * 8;
  localparam int T  = 1000;

  logic          clk, rst_n, rx_valid, cmd_sent;
  logic [7:0]    rx_data;
  logic [TW-1:0] line_text;
  logic          line_valid, resp_ok, resp_error, resp_prompt, resp_timeout, busy, overflow;

  gsm_at_resp_parser #(
    .LINE_CHARS    (LC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd_sent    (cmd_sent),
    .line_text   (line_text),
    .line_valid  (line_valid),
    .resp_ok     (resp_ok),
    .resp_error  (resp_error),
    .resp_prompt (resp_prompt),
    .resp_timeout(resp_timeout),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_text(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: the current line as a byte queue, timeout as an absolute deadline edge.
  logic [7:0]    mline[$];
  bit            mtrunc, mbusy, moverflow;
  int            n_edge, mdeadline;
  logic [TW-1:0] exp_text;
  bit            exp_valid, exp_ok, exp_err, exp_prompt, exp_timeout;
  bit            run_cmp = 1'b0;

  function automatic logic [TW-1:0] pad_line();
    logic [TW-1:0] r = {LC{8'h20}};
    for (int i = 0; i < mline.size(); i++) r[8*(LC-1-i) +: 8] = mline[i];
    return r;
  endfunction

  function automatic bit line_is(input string s, input bit exact);
    if (mline.size() < s.len()) return 1'b0;
    if (exact && mline.size() != s.len()) return 1'b0;
    for (int i = 0; i < s.len(); i++) if (mline[i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mline.delete();
    mtrunc = 0; mbusy = 0; moverflow = 0; mdeadline = -1;
    exp_text = {LC{8'h20}};
    exp_valid = 0; exp_ok = 0; exp_err = 0; exp_prompt = 0; exp_timeout = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit cs);
    bit ok = 0, err = 0, pr = 0, drop = 0;
    n_edge++;
    exp_valid = 0; exp_timeout = 0;
    if (v && d != 8'h0D) begin
      if (d == 8'h0A) begin
        if (mline.size() != 0) begin
          exp_text  = pad_line();
          exp_valid = 1;
          ok  = !mtrunc && line_is("OK", 1);
          err = line_is("ERROR", 1) || line_is("+CME ERROR", 0);
          mline.delete();
          mtrunc = 0;
        end
      end else if (d >= 8'h20 && d <= 8'h7E) begin
        if (mline.size() == 1 && mline[0] == ">" && d == " ") begin
          pr = 1;
          mline.push_back(d);
          exp_text  = pad_line();
          exp_valid = 1;
          mline.delete();
        end else if (mline.size() < LC) begin
          mline.push_back(d);
        end else begin
          drop = 1;
          mtrunc = 1;
        end
      end
    end
    if (cs) moverflow = 0;
    if (drop) moverflow = 1;
    if (cs) begin
      mbusy = 1;
      mdeadline = n_edge + T - 1;
    end else if (ok || err || pr) begin
      mbusy = 0;
    end else if (mbusy && n_edge == mdeadline) begin
      exp_timeout = 1;
      mbusy = 0;
    end
    exp_ok = ok; exp_err = err; exp_prompt = pr;
  endtask

  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      check_text("line_text", line_text, exp_text);
      check_bit("line_valid", line_valid, exp_valid);
      check_bit("resp_ok", resp_ok, exp_ok);
      check_bit("resp_error", resp_error, exp_err);
      check_bit("resp_prompt", resp_prompt, exp_prompt);
      check_bit("resp_timeout", resp_timeout, exp_timeout);
      check_bit("busy", busy, mbusy);
      check_bit("overflow", overflow, moverflow);
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit cs);
    rx_valid = v; rx_data = d; cmd_sent = cs;
    @(posedge clk);
    model_edge(v, d, cs);
    #1;
    rx_valid = 0; cmd_sent = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic send_str(input string s, input bit rcmd);
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i], rcmd && ($urandom_range(0, 19) == 0));
      if (i < s.len() - 1) idle($urandom_range(0, 2));
    end
  endtask

  task automatic crlf(input bit rcmd);
    step(1, 8'h0D, rcmd && ($urandom_range(0, 19) == 0));
    step(1, 8'h0A, rcmd && ($urandom_range(0, 19) == 0));
  endtask

  task automatic measure(input bit reload, output int at);
    at = -1;
    step(0, 8'h00, 1);
    for (int cur = 1; cur <= 2000 && at < 0; cur++) begin
      if (resp_timeout) at = cur;
      else step(0, 8'h00, reload && cur == 500);
    end
  endtask

  string words[9] = '{"OK", "ERROR", "+CME ERROR: 3", "> ", "AT", "RING", "+CSQ: 21,0",
                      "AT+CMGS=\"0123456789012\"", ">x"};

  initial begin
    int at, cnt;
    rst_n = 0; rx_valid = 0; cmd_sent = 0; rx_data = 8'h00; n_edge = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_text("reset line_text", line_text, {LC{8'h20}});
    check_bit("reset line_valid", line_valid, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1;
    run_cmp = 1;

    // 1: OK after command
    step(0, 8'h00, 1);
    check_bit("s1 busy after cmd", busy, 1'b1);
    crlf(0); send_str("OK", 0); crlf(0);
    check_bit("s1 line_valid", line_valid, 1'b1);
    check_text("s1 line_text", line_text, {"OK", {12{8'h20}}});
    check_bit("s1 resp_ok", resp_ok, 1'b1);
    check_bit("s1 busy cleared", busy, 1'b0);
    cnt = 0;
    for (int i = 0; i < T + 100; i++) begin
      step(0, 8'h00, 0);
      if (resp_timeout) cnt++;
    end
    check_int("s1 no timeout", cnt, 0);

    // 2: +CME ERROR
    step(0, 8'h00, 1);
    send_str("+CME ERROR: 10", 0); crlf(0);
    check_bit("s2 resp_error", resp_error, 1'b1);
    check_bit("s2 overflow", overflow, 1'b0);
    check_text("s2 line_text", line_text, "+CME ERROR: 10");

    // 3: over-long line
    send_str("AT+CMGS=\"123456789\"", 0); crlf(0);
    check_text("s3 line_text", line_text, "AT+CMGS=\"12345");
    check_bit("s3 overflow", overflow, 1'b1);
    check_bit("s3 resp_ok", resp_ok, 1'b0);
    check_bit("s3 resp_error", resp_error, 1'b0);
    step(0, 8'h00, 1);
    check_bit("s3 overflow cleared", overflow, 1'b0);

    // 4: prompt without LF, then OK
    step(0, 8'h00, 1);
    send_str("> ", 0);
    check_bit("s4 resp_prompt", resp_prompt, 1'b1);
    check_text("s4 line_text", line_text, {">", " ", {12{8'h20}}});
    check_bit("s4 busy", busy, 1'b0);
    send_str("OK", 0); crlf(0);
    check_bit("s4 resp_ok", resp_ok, 1'b1);

    // 5: timeout, plain and with restart at cycle 500
    measure(0, at);
    check_int("s5 timeout cycle", at, 1000);
    check_bit("s5 busy after timeout", busy, 1'b0);
    measure(1, at);
    check_int("s5 restarted timeout cycle", at, 1500);

    // Terminator registered on the same edge the counter expires
    step(0, 8'h00, 1);
    idle(996);
    step(1, "O", 0); step(1, "K", 0); step(1, 8'h0A, 0);
    check_bit("tie resp_ok", resp_ok, 1'b1);
    check_bit("tie resp_timeout", resp_timeout, 1'b0);
    check_bit("tie busy", busy, 1'b0);
    step(0, 8'h00, 0);
    check_bit("tie no late timeout", resp_timeout, 1'b0);

    // 6: reset mid-line
    step(0, 8'h00, 1);
    send_str("ER", 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_text("s6 reset line_text", line_text, {LC{8'h20}});
    check_bit("s6 reset busy", busy, 1'b0);
    check_bit("s6 reset overflow", overflow, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    send_str("ROR", 0); crlf(0);
    check_bit("s6 line_valid", line_valid, 1'b1);
    check_text("s6 line_text", line_text, {"ROR", {11{8'h20}}});
    check_bit("s6 resp_error", resp_error, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: begin
          send_str(words[$urandom_range(0, 8)], 1);
          if ($urandom_range(0, 3) != 0) crlf(1);
        end
        5: for (int k = 0; k < int'($urandom_range(1, 5)); k++)
             step(1, 8'($urandom_range(0, 255)), 0);
        6: step(0, 8'h00, 1);
        7: idle($urandom_range(1, 1100));
        8: begin step(0, 8'h00, 1); send_str("> ", 0); end
        default: idle($urandom_range(0, 20));
      endcase
    end
    idle(5);
    run_cmp = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
